// File: rtl/lsq_writeback.sv
// Load/store completion writeback: buffers LSQ completions in a small FIFO,
// walks the 8 lanes of each completion issuing memory strobes, writes load
// results back to the register file and signals the end of each completion.
module lsq_writeback #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             done_in,
  input  logic [1:0]                       warp_num_in,
  input  logic [3:0]                       dest_reg_in,
  input  logic [7:0][ADDR_WIDTH-1:0]       addr_in,
  input  logic                             instr_bit_in,
  input  logic [3:0]                       threads_mask_in,
  input  logic [7:0][DATA_WIDTH-1:0]       reg_data_in,
  output logic                             mem_re,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             rf_we,
  output logic [1:0]                       rf_warp,
  output logic [3:0]                       rf_reg,
  output logic [2:0]                       rf_lane,
  output logic [DATA_WIDTH-1:0]            rf_wdata,
  output logic                             warp_done,
  output logic [1:0]                       warp_done_num,
  output logic                             warp_done_store,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [1:0]                 warp;
    logic [3:0]                 rd;
    logic [7:0][ADDR_WIDTH-1:0] addr;
    logic                       store;
    logic [3:0]                 mask;
    logic [7:0][DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [2:0]       lane;
  entry_t           work;
  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  entry_t     in_entry;
  entry_t     head;
  entry_t     sel;
  logic [2:0] drive_lane;
  logic       lane_en;
  logic       pop_c;
  logic       push_c;
  logic       drive_c;

  assign in_entry = '{warp: warp_num_in, rd: dest_reg_in, addr: addr_in,
                      store: instr_bit_in, mask: threads_mask_in, data: reg_data_in};
  assign head     = fifo_mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push alongside it is always accepted.
  assign pop_c   = (state == IDLE) && (fifo_count != '0);
  assign push_c  = done_in && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop_c);
  assign drive_c = pop_c || ((state == SCAN) && (lane != 3'd7));

  // Read data arrives the cycle after mem_re, which is the cycle rf_we is high.
  assign rf_wdata = rf_we ? mem_rdata : '0;

  // Select the lane whose strobes are registered at the next edge.
  always_comb begin
    sel        = work;
    drive_lane = lane + 3'd1;
    if (state == IDLE) begin
      sel        = head;
      drive_lane = 3'd0;
    end
    lane_en = sel.mask[drive_lane[2:1]];
  end

  // Completion FIFO payload storage.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= in_entry;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop_c && !push_c) fifo_count <= fifo_count - CNT_W'(1);
      if (done_in && !push_c) overflow <= 1'b1;
    end
  end

  // Lane-scan FSM with registered memory, register-file and completion outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      lane            <= 3'd0;
      work            <= '0;
      mem_re          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      rf_we           <= 1'b0;
      rf_warp         <= 2'd0;
      rf_reg          <= 4'd0;
      rf_lane         <= 3'd0;
      warp_done       <= 1'b0;
      warp_done_num   <= 2'd0;
      warp_done_store <= 1'b0;
    end else begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      warp_done <= 1'b0;
      rf_we     <= mem_re;
      rf_lane   <= lane;
      rf_warp   <= work.warp;
      rf_reg    <= work.rd;

      if (drive_c) begin
        mem_re <= lane_en && !sel.store;
        mem_we <= lane_en && sel.store;
        if (lane_en) begin
          mem_addr <= sel.addr[drive_lane];
          if (sel.store) mem_wdata <= sel.data[drive_lane];
        end
      end

      unique case (state)
        IDLE: begin
          if (pop_c) begin
            work  <= head;
            lane  <= 3'd0;
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (lane == 3'd7) begin
            state           <= DONE;
            warp_done       <= 1'b1;
            warp_done_num   <= work.warp;
            warp_done_store <= work.store;
          end else begin
            lane <= lane + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsq_writeback.sv
// Directed bench for lsq_writeback: table of single completions plus
// hand-written sequences for overflow, DONE-cycle push and mid-scan reset.
module tb_lsq_writeback;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             done_in;
  logic [1:0]       warp_num_in;
  logic [3:0]       dest_reg_in;
  logic [7:0][7:0]  addr_in;
  logic             instr_bit_in;
  logic [3:0]       threads_mask_in;
  logic [7:0][15:0] reg_data_in;
  logic             mem_re, mem_we;
  logic [7:0]       mem_addr;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata = '0;
  logic             rf_we;
  logic [1:0]       rf_warp;
  logic [3:0]       rf_reg;
  logic [2:0]       rf_lane;
  logic [15:0]      rf_wdata;
  logic             warp_done;
  logic [1:0]       warp_done_num;
  logic             warp_done_store;
  logic             busy;
  logic [2:0]       fifo_count;
  logic             overflow;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem_model [256];

  lsq_writeback #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .warp_num_in(warp_num_in),
    .dest_reg_in(dest_reg_in), .addr_in(addr_in), .instr_bit_in(instr_bit_in),
    .threads_mask_in(threads_mask_in), .reg_data_in(reg_data_in),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_warp(rf_warp), .rf_reg(rf_reg),
    .rf_lane(rf_lane), .rf_wdata(rf_wdata), .warp_done(warp_done),
    .warp_done_num(warp_done_num), .warp_done_store(warp_done_store),
    .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  // Synchronous data memory: read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_model[mem_addr];
  end

  typedef struct {
    logic [1:0]  warp;
    logic [3:0]  rd;
    logic [3:0]  mask;
    logic        store;
    logic [7:0]  abase;
    logic [15:0] dlo;
    logic [15:0] d6;
    logic [15:0] d7;
    logic [7:0]  exp_re;   // bit k: mem_re expected at t+1+k
    logic [7:0]  exp_we;   // bit k: mem_we expected at t+1+k
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lane_data(input vec_t v, input int k);
    if (k == 6) return v.d6;
    if (k == 7) return v.d7;
    return 16'(v.dlo + 16'(k));
  endfunction

  task automatic load_fields(input vec_t v);
    warp_num_in     = v.warp;
    dest_reg_in     = v.rd;
    threads_mask_in = v.mask;
    instr_bit_in    = v.store;
    for (int k = 0; k < 8; k++) begin
      addr_in[k]     = 8'(v.abase + 8'(k));
      reg_data_in[k] = lane_data(v, k);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " mem_re"}, 32'(mem_re), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, " rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, " rf_warp"}, 32'(rf_warp), 32'd0);
    chk({tag, " rf_reg"}, 32'(rf_reg), 32'd0);
    chk({tag, " rf_lane"}, 32'(rf_lane), 32'd0);
    chk({tag, " rf_wdata"}, 32'(rf_wdata), 32'd0);
    chk({tag, " warp_done"}, 32'(warp_done), 32'd0);
    chk({tag, " warp_done_num"}, 32'(warp_done_num), 32'd0);
    chk({tag, " warp_done_store"}, 32'(warp_done_store), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
  endtask

  // One completion from idle; k counts cycles after the pop cycle t.
  task automatic run_vec(input int vi);
    vec_t v;
    logic e_re, e_we, e_rf;
    int   l;
    string tg;
    v = vecs[vi];
    load_fields(v);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk($sformatf("v%0d t busy", vi), 32'(busy), 32'd0);
    chk($sformatf("v%0d t count", vi), 32'(fifo_count), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      tg = $sformatf("v%0d t+%0d", vi, k);
      e_re = 1'b0;
      e_we = 1'b0;
      e_rf = 1'b0;
      if (k <= 8) begin
        e_re = v.exp_re[k-1];
        e_we = v.exp_we[k-1];
      end
      if (k >= 2 && k <= 9) e_rf = v.exp_re[k-2];
      chk({tg, " mem_re"}, 32'(mem_re), 32'(e_re));
      chk({tg, " mem_we"}, 32'(mem_we), 32'(e_we));
      chk({tg, " rf_we"}, 32'(rf_we), 32'(e_rf));
      chk({tg, " warp_done"}, 32'(warp_done), 32'(k == 9));
      chk({tg, " busy"}, 32'(busy), 32'(k <= 9));
      if (e_re || e_we) begin
        l = k - 1;
        chk({tg, " mem_addr"}, 32'(mem_addr), 32'(8'(v.abase + 8'(l))));
        if (e_we) chk({tg, " mem_wdata"}, 32'(mem_wdata), 32'(lane_data(v, l)));
      end
      if (e_rf) begin
        l = k - 2;
        chk({tg, " rf_lane"}, 32'(rf_lane), 32'(l));
        chk({tg, " rf_warp"}, 32'(rf_warp), 32'(v.warp));
        chk({tg, " rf_reg"}, 32'(rf_reg), 32'(v.rd));
        chk({tg, " rf_wdata"}, 32'(rf_wdata), 32'(mem_model[8'(v.abase + 8'(l))]));
      end
      if (k == 9) begin
        chk({tg, " done_num"}, 32'(warp_done_num), 32'(v.warp));
        chk({tg, " done_store"}, 32'(warp_done_store), 32'(v.store));
      end
    end
    chk($sformatf("v%0d end count", vi), 32'(fifo_count), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] warps [6];
    logic [2:0] exp_cnt [6];
    int cyc, npulse, act_cnt;
    vec_t v;

    for (int i = 0; i < 256; i++) mem_model[i] = 16'(i * 257) ^ 16'h3C00;
    mem_model[10] = 16'hA5A5;
    mem_model[11] = 16'h5A5A;

    //            warp rd     mask     st    abase   dlo        d6         d7         re     we
    vecs[0] = '{2'd2, 4'd5,  4'b0001, 1'b0, 8'd10,  16'h0000, 16'h0000, 16'h0000, 8'h03, 8'h00};
    vecs[1] = '{2'd1, 4'd3,  4'b1000, 1'b1, 8'd40,  16'h1000, 16'h1234, 16'h5678, 8'h00, 8'hC0};
    vecs[2] = '{2'd3, 4'd9,  4'b0000, 1'b0, 8'd60,  16'h0000, 16'h0000, 16'h0000, 8'h00, 8'h00};
    vecs[3] = '{2'd0, 4'd15, 4'b0101, 1'b0, 8'd100, 16'h0000, 16'h0000, 16'h0000, 8'h33, 8'h00};
    vecs[4] = '{2'd3, 4'd1,  4'b1111, 1'b1, 8'd200, 16'hBEE0, 16'hCAFE, 16'hF00D, 8'h00, 8'hFF};
    vecs[5] = '{2'd2, 4'd7,  4'b0110, 1'b1, 8'd250, 16'h0700, 16'h0606, 16'h0707, 8'h00, 8'h3C};
    vecs[6] = '{2'd1, 4'd12, 4'b1010, 1'b0, 8'd128, 16'h0000, 16'h0000, 16'h0000, 8'hCC, 8'h00};

    reset = 1'b0;
    done_in = 1'b0;
    load_fields(vecs[0]);
    #1;
    check_all_zero("reset");
    do_reset();

    // Single completions, one per table entry.
    for (int vi = 0; vi < NV; vi++) run_vec(vi);

    // Reset in the middle of a scan abandons the completion.
    v = '{2'd1, 4'd2, 4'b1111, 1'b0, 8'd20, 16'h0, 16'h0, 16'h0, 8'hFF, 8'h00};
    load_fields(v);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("midscan pre mem_re", 32'(mem_re), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("midscan reset");
    #2;
    reset = 1'b1;
    act_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mem_re || mem_we || rf_we || warp_done) act_cnt++;
    end
    chk("midscan post activity", 32'(act_cnt), 32'd0);

    // Push during DONE with room: accepted and popped at the following IDLE.
    v = '{2'd1, 4'd4, 4'b0000, 1'b0, 8'd0, 16'h0, 16'h0, 16'h0, 8'h00, 8'h00};
    load_fields(v);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    chk("donepush first done", 32'(warp_done), 32'd1);
    warp_num_in  = 2'd3;
    instr_bit_in = 1'b1;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("donepush count", 32'(fifo_count), 32'd1);
    chk("donepush ovf", 32'(overflow), 32'd0);
    for (int k = 11; k <= 19; k++) begin
      tick();
      chk($sformatf("donepush t+%0d warp_done", k), 32'(warp_done), 32'(k == 19));
    end
    chk("donepush num", 32'(warp_done_num), 32'd3);
    chk("donepush store", 32'(warp_done_store), 32'd1);
    tick();

    // Push during DONE with a full FIFO: no pop that cycle, so it is dropped.
    v = '{2'd0, 4'd4, 4'b0000, 1'b0, 8'd0, 16'h0, 16'h0, 16'h0, 8'h00, 8'h00};
    load_fields(v);
    done_in = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) tick();
    done_in = 1'b0;
    chk("full count", 32'(fifo_count), 32'd4);
    chk("full ovf before", 32'(overflow), 32'd0);
    for (int k = 5; k <= 9; k++) tick();
    chk("full in DONE", 32'(warp_done), 32'd1);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("full ovf after", 32'(overflow), 32'd1);
    chk("full count after", 32'(fifo_count), 32'd4);
    for (int k = 0; k < 15; k++) tick();
    chk("ovf sticky", 32'(overflow), 32'd1);
    do_reset();
    #1;
    chk("ovf cleared", 32'(overflow), 32'd0);
    chk("count cleared", 32'(fifo_count), 32'd0);

    // Six back-to-back completions from idle: five served, sixth dropped.
    warps   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    v = '{2'd0, 4'd6, 4'b0000, 1'b0, 8'd0, 16'h0, 16'h0, 16'h0, 8'h00, 8'h00};
    load_fields(v);
    cyc = 0;
    done_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      warp_num_in = warps[i];
      tick();
      cyc++;
      chk($sformatf("burst%0d count", i), 32'(fifo_count), 32'(exp_cnt[i]));
      chk($sformatf("burst%0d ovf", i), 32'(overflow), 32'(i == 5));
    end
    done_in = 1'b0;
    npulse = 0;
    while (cyc < 70) begin
      tick();
      cyc++;
      if (warp_done) begin
        chk($sformatf("burst pulse%0d cycle", npulse), 32'(cyc), 32'(10 + 10 * npulse));
        if (npulse < 5)
          chk($sformatf("burst pulse%0d num", npulse), 32'(warp_done_num), 32'(warps[npulse]));
        npulse++;
      end
    end
    chk("burst pulses", 32'(npulse), 32'd5);
    chk("burst end count", 32'(fifo_count), 32'd0);
    chk("burst end ovf", 32'(overflow), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsq_writeback.md
LSQ_WRITEBACK -- requirements
Module: lsq_writeback

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the data word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the data-memory address width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of completion-buffer entries (power of 2).

Interface
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 done_in  input  1  one-cycle completion strobe from the load/store queue.
REQ-007 warp_num_in  input  2  warp of the completion.
REQ-008 dest_reg_in  input  4  destination register for loads.
REQ-009 addr_in  input  ADDR_WIDTH x8  per-lane address.
REQ-010 instr_bit_in  input  1  0 = load, 1 = store.
REQ-011 threads_mask_in  input  4  bit k enables lanes 2k and 2k+1.
REQ-012 reg_data_in  input  DATA_WIDTH x8  per-lane store data.
REQ-013 mem_re / mem_we  output  1 each  data-memory read / write strobe.
REQ-014 mem_addr  output  ADDR_WIDTH  memory address.
REQ-015 mem_wdata  output  DATA_WIDTH  store data.
REQ-016 mem_rdata  input  DATA_WIDTH  read data, valid exactly one cycle after mem_re.
REQ-017 rf_we  output  1  register-file write strobe.
REQ-018 rf_warp  output  2  register-file warp.
REQ-019 rf_reg  output  4  register-file register.
REQ-020 rf_lane  output  3  register-file lane.
REQ-021 rf_wdata  output  DATA_WIDTH  register-file write data.
REQ-022 warp_done  output  1  one-cycle strobe marking the end of a completion.
REQ-023 warp_done_num  output  2  warp number of that completion.
REQ-024 warp_done_store  output  1  instr_bit of that completion.
REQ-025 busy  output  1  asserted when the FSM is not in IDLE.
REQ-026 fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-027 overflow  output  1  sticky flag for a dropped completion.

Function
REQ-028 The block SHALL push all done_in fields into the FIFO when done_in=1 and (count<FIFO_DEPTH or a pop occurs in the same cycle); a simultaneous push and pop SHALL leave count unchanged.
REQ-029 If done_in=1 while the FIFO is full with no pop, the completion SHALL be dropped, overflow SHALL set, and overflow SHALL clear only on reset.
REQ-030 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-031 IDLE: when count>0, the FSM SHALL pop the head into working registers, set lane=0 and go to SCAN; when count=0 it SHALL stay in IDLE.
REQ-032 SCAN: the FSM SHALL spend exactly 8 cycles on lanes 0..7, then go to DONE.
REQ-033 Per SCAN cycle, for an enabled store lane: mem_we=1, mem_addr=addr[lane], mem_wdata=reg_data[lane].
REQ-034 Per SCAN cycle, for an enabled load lane: mem_re=1, mem_addr=addr[lane].
REQ-035 Per SCAN cycle, for a disabled lane: no strobes.
REQ-036 The cycle after each mem_re, rf_we SHALL be 1 with rf_wdata=mem_rdata and rf_warp/rf_reg/rf_lane taken from that load; the lane-7 writeback coincides with DONE.
REQ-037 DONE: the FSM SHALL pulse warp_done for one cycle with warp_done_num and warp_done_store, then go to IDLE.
REQ-038 Latency: pop at cycle t, SCAN t+1..t+8, warp_done at t+9, next pop no earlier than t+10 (10-cycle period per completion).
REQ-039 mem_we and mem_re SHALL never both be 1.
REQ-040 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-041 A mask of 0 SHALL still take the full 10-cycle period and pulse warp_done, with no memory or register-file activity.
REQ-042 A push during the final DONE cycle SHALL be accepted and popped at the next IDLE.

Reset
REQ-043 reset=0 SHALL asynchronously force FSM=IDLE and FIFO pointers/count=0.
REQ-044 reset=0 SHALL asynchronously clear overflow, mem_re, mem_we, rf_we and warp_done.
REQ-045 reset=0 SHALL asynchronously clear mem_addr, mem_wdata, rf_warp, rf_reg, rf_lane, rf_wdata, warp_done_num and warp_done_store.
REQ-046 A reset asserted mid-SCAN SHALL abandon the completion with no further strobes and no warp_done.

Verification
REQ-047 Load warp 2, reg 5, mask 4'b0001, addr {10,11,...}, mem returns 16'hA5A5/16'h5A5A -> mem_re at t+1 and t+2; rf_we at t+2 (lane0, 16'hA5A5) and t+3 (lane1, 16'h5A5A); warp_done at t+9 with num=2, store=0.
REQ-048 Store mask 4'b1000, data lanes6/7=16'h1234/16'h5678 -> mem_we only at t+7 and t+8 with those values; warp_done_store=1.
REQ-049 Six back-to-back done_in pulses with the FSM idle -> first popped immediately; the FIFO holds the next four; the sixth sets overflow; exactly 5 warp_done pulses, spaced 10 cycles.
REQ-050 Mask 4'b0000 -> no mem/rf strobes; warp_done at t+9.
REQ-051 reset pulsed low at t+4 of a load -> all outputs 0 immediately; no warp_done; count=0.
REQ-052 done_in during DONE with FIFO full-minus-zero (count=FIFO_DEPTH) -> push succeeds only if a pop occurs the same cycle, else overflow=1.
